// File: rtl/types_pkg.sv
// Shared types and sizes for the rename stage: decode/rename packets, tag widths and free-list pointer math.
package types_pkg;

    localparam int NUM_AREG = 32;
    localparam int NUM_PREG = 128;
    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;

    typedef logic [6:0] preg_t;
    typedef logic [4:0] areg_t;
    typedef logic [6:0] fl_ptr_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [31:0] pc;
        areg_t       rs1;
        areg_t       rs2;
        areg_t       rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic        fu_alu;
        logic        fu_mem;
        logic        fu_br;
    } decode_data;

    typedef struct packed {
        preg_t      ps1;
        preg_t      ps2;
        preg_t      pd_new;
        preg_t      pd_old;
        decode_data dec;
    } rename_data;

    function automatic fl_ptr_t fl_inc(input fl_ptr_t p);
        return (p == fl_ptr_t'(FL_DEPTH - 1)) ? '0 : p + 7'd1;
    endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical tags: allocate at head, return retired tags at tail,
// and roll the head back to a checkpoint on branch recovery.
module free_list
    import types_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       alloc_i,
    output preg_t      alloc_tag_o,
    output fl_ptr_t    head_o,
    input  logic       free_i,
    input  preg_t      free_tag_i,
    input  logic       restore_i,
    input  fl_ptr_t    restore_head_i,
    output logic [6:0] count_o
);

    preg_t      fl_q [FL_DEPTH];
    fl_ptr_t    head_q, head_d;
    fl_ptr_t    tail_q, tail_d;
    logic [6:0] count_q, count_d;
    fl_ptr_t    rollback;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rollback = '0;
        if (free_i) begin
            tail_d = fl_inc(tail_q);
        end
        if (restore_i) begin
            // Entries handed out since the checkpoint become free again.
            rollback = (head_q >= restore_head_i) ? head_q - restore_head_i
                                                  : head_q + 7'(FL_DEPTH) - restore_head_i;
            head_d   = restore_head_i;
            count_d  = count_q + rollback + {6'd0, free_i};
        end else begin
            if (alloc_i) begin
                head_d = fl_inc(head_q);
            end
            count_d = count_q + {6'd0, free_i} - {6'd0, alloc_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= preg_t'(NUM_AREG + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 7'(FL_DEPTH);
        end else begin
            if (free_i) begin
                fl_q[tail_q] <= free_tag_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign alloc_tag_o = fl_q[head_q];
    assign head_o      = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: map table, single branch checkpoint and registered output toward dispatch.
// Optional RENAME_PERF_CNT_EN adds saturating perf_renamed / perf_fl_stall counters.
module rename_stage
    import types_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  decode_data data_in,
    output logic       ready_in,
    output logic       valid_out,
    output rename_data data_out,
    input  logic       ready_out,
    input  logic       commit_valid,
    input  preg_t      commit_pd_old,
    input  logic       br_resolve_valid,
    input  logic       mispredict,
    output logic [6:0] free_count
`ifdef RENAME_PERF_CNT_EN
    ,
    output logic [31:0] perf_renamed,
    output logic [31:0] perf_fl_stall
`endif
);

    // Handshake: a packet moves on any edge where valid and ready are both high;
    // valid_out stays asserted with data_out frozen until dispatch raises ready_out.

    preg_t      map_q [NUM_AREG];
    preg_t      map_d [NUM_AREG];
    preg_t      ckpt_map_q [NUM_AREG];
    fl_ptr_t    ckpt_head_q;
    logic       ckpt_valid_q;
    logic       valid_out_q;
    rename_data data_out_q;
    rename_data pkt;

    preg_t      fl_tag;
    fl_ptr_t    fl_head;
    logic [6:0] fl_count;
    logic       needs_pd, accept, alloc, restore, do_free;

    always_comb begin
        needs_pd = data_in.rd_we && (data_in.rd != '0);
        ready_in = !mispredict && (!valid_out_q || ready_out)
                   && (!needs_pd || fl_count != '0)
                   && !(data_in.fu_br && ckpt_valid_q);
        accept   = valid_in && ready_in;
        alloc    = accept && needs_pd;
        restore  = mispredict && ckpt_valid_q;
        do_free  = commit_valid && (commit_pd_old != '0);
    end

    // Sources and pd_old see the map as it was before this instruction's own write.
    always_comb begin
        pkt     = '0;
        pkt.dec = data_in;
        pkt.ps1 = (data_in.rs1 == '0) ? '0 : map_q[data_in.rs1];
        pkt.ps2 = (data_in.rs2 == '0) ? '0 : map_q[data_in.rs2];
        if (needs_pd) begin
            pkt.pd_new = fl_tag;
            pkt.pd_old = map_q[data_in.rd];
        end
    end

    always_comb begin
        map_d = map_q;
        if (restore) begin
            map_d = ckpt_map_q;
        end else if (alloc) begin
            map_d[data_in.rd] = fl_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                map_q[i]      <= preg_t'(i);
                ckpt_map_q[i] <= preg_t'(i);
            end
            ckpt_head_q  <= '0;
            ckpt_valid_q <= 1'b0;
        end else begin
            map_q <= map_d;
            if (mispredict) begin
                ckpt_valid_q <= 1'b0;
            end else if (accept && data_in.fu_br) begin
                // Snapshot includes the branch's own link-register write (JAL/JALR).
                ckpt_valid_q <= 1'b1;
                ckpt_map_q   <= map_d;
                ckpt_head_q  <= alloc ? fl_inc(fl_head) : fl_head;
            end else if (br_resolve_valid) begin
                ckpt_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else if (mispredict) begin
            valid_out_q <= 1'b0;
        end else if (accept) begin
            valid_out_q <= 1'b1;
            data_out_q  <= pkt;
        end else if (ready_out) begin
            valid_out_q <= 1'b0;
        end
    end

    free_list u_free_list (
        .clk_i          (clk),
        .rst_ni         (reset),
        .alloc_i        (alloc),
        .alloc_tag_o    (fl_tag),
        .head_o         (fl_head),
        .free_i         (do_free),
        .free_tag_i     (commit_pd_old),
        .restore_i      (restore),
        .restore_head_i (ckpt_head_q),
        .count_o        (fl_count)
    );

    assign valid_out  = valid_out_q;
    assign data_out   = data_out_q;
    assign free_count = fl_count;

`ifdef RENAME_PERF_CNT_EN
    logic [31:0] perf_renamed_q, perf_fl_stall_q;
    logic        fl_stall;

    assign fl_stall = valid_in && needs_pd && (fl_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_renamed_q  <= '0;
            perf_fl_stall_q <= '0;
        end else begin
            if (accept && perf_renamed_q != '1) begin
                perf_renamed_q <= perf_renamed_q + 32'd1;
            end
            if (fl_stall && perf_fl_stall_q != '1) begin
                perf_fl_stall_q <= perf_fl_stall_q + 32'd1;
            end
        end
    end

    assign perf_renamed  = perf_renamed_q;
    assign perf_fl_stall = perf_fl_stall_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios plus a randomized run against a queue-based rename model.
module tb_rename_stage;
    import types_pkg::*;

    localparam int W = 60;

    logic       clk;
    logic       reset;
    logic       valid_in;
    decode_data data_in;
    logic       ready_in;
    logic       valid_out;
    rename_data data_out;
    logic       ready_out;
    logic       commit_valid;
    preg_t      commit_pd_old;
    logic       br_resolve_valid;
    logic       mispredict;
    logic [6:0] free_count;
`ifdef RENAME_PERF_CNT_EN
    logic [31:0] perf_renamed, perf_fl_stall;
`endif

    rename_stage dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .ready_in         (ready_in),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .ready_out        (ready_out),
        .commit_valid     (commit_valid),
        .commit_pd_old    (commit_pd_old),
        .br_resolve_valid (br_resolve_valid),
        .mispredict       (mispredict),
        .free_count       (free_count)
`ifdef RENAME_PERF_CNT_EN
        ,
        .perf_renamed     (perf_renamed),
        .perf_fl_stall    (perf_fl_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: map as int array, free list as an in-order queue of tags
    int           m_map [32];
    int           m_ck_map [32];
    int           m_fl [$];
    int           m_ck_allocs [$];
    bit           m_ckv;
    bit           m_vout;
    logic [W-1:0] m_dout;
    logic [W-1:0] exp_q [$];

    function automatic logic [W-1:0] pack(input logic [31:0] pc, input int a, input int b,
                                          input int c, input int d);
        return {pc, 7'(a), 7'(b), 7'(c), 7'(d)};
    endfunction

    function automatic logic [W-1:0] obs_pkt();
        return {data_out.dec.pc, data_out.ps1, data_out.ps2, data_out.pd_new, data_out.pd_old};
    endfunction

    function automatic bit m_needs();
        return data_in.rd_we && (data_in.rd != 5'd0);
    endfunction

    function automatic bit m_ready();
        return !mispredict && (!m_vout || ready_out) && (!m_needs() || m_fl.size() != 0)
               && !(data_in.fu_br && m_ckv);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i;
            m_ck_map[i] = i;
        end
        m_fl.delete();
        for (int i = 0; i < 96; i++) m_fl.push_back(32 + i);
        m_ck_allocs.delete();
        exp_q.delete();
        m_ckv = 0;
        m_vout = 0;
        m_dout = '0;
    endtask

    task automatic model_edge();
        bit acc;
        int ps1, ps2, pdn, pdo;
        acc = valid_in && m_ready();
        if (mispredict) begin
            if (m_ckv) begin
                m_map = m_ck_map;
                for (int i = m_ck_allocs.size() - 1; i >= 0; i--) m_fl.push_front(m_ck_allocs[i]);
            end
            m_ckv = 0;
            m_vout = 0;
            exp_q.delete();
        end else if (acc) begin
            ps1 = (data_in.rs1 == 0) ? 0 : m_map[data_in.rs1];
            ps2 = (data_in.rs2 == 0) ? 0 : m_map[data_in.rs2];
            pdn = 0;
            pdo = 0;
            if (m_needs()) begin
                pdn = m_fl.pop_front();
                pdo = m_map[data_in.rd];
                m_map[data_in.rd] = pdn;
                if (m_ckv) m_ck_allocs.push_back(pdn);
            end
            m_dout = pack(data_in.pc, ps1, ps2, pdn, pdo);
            m_vout = 1;
            exp_q.push_back(m_dout);
            if (data_in.fu_br) begin
                m_ckv = 1;
                m_ck_map = m_map;
                m_ck_allocs.delete();
            end else if (br_resolve_valid) begin
                m_ckv = 0;
            end
        end else begin
            if (ready_out) m_vout = 0;
            if (br_resolve_valid) m_ckv = 0;
        end
        if (commit_valid && commit_pd_old != 0) m_fl.push_back(int'(commit_pd_old));
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        valid_in = 0;
        data_in = '0;
        ready_out = 1;
        commit_valid = 0;
        commit_pd_old = '0;
        br_resolve_valid = 0;
        mispredict = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input int rd, input int rs1, input int rs2,
                             input bit we, input bit br);
        data_in = '0;
        data_in.pc = pc;
        data_in.rd = 5'(rd);
        data_in.rs1 = 5'(rs1);
        data_in.rs2 = 5'(rs2);
        data_in.rd_we = we;
        data_in.fu_br = br;
        data_in.fu_alu = !br;
        valid_in = 1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %0b want 0", valid_out); end
        n_cmp++; if (free_count !== 7'd96) begin n_bad++; $display("FAIL reset_free_count: got %0d want 96", free_count); end
        n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready_in: got %0b want 1", ready_in); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    endtask

    task automatic test_basic();
        do_reset();
        set_instr(32'd100, 1, 2, 3, 1, 0);
        tick();
        valid_in = 0;
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", valid_out); end
        n_cmp++; if (obs_pkt() !== pack(100, 2, 3, 32, 1)) begin n_bad++; $display("FAIL basic_pkt: got %h want %h", obs_pkt(), pack(100, 2, 3, 32, 1)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_instr(32'd200, 5, 0, 0, 1, 0);
        tick();
        set_instr(32'd204, 6, 5, 5, 1, 0);
        @(negedge clk);
        n_cmp++; if (obs_pkt() !== pack(200, 0, 0, 32, 5)) begin n_bad++; $display("FAIL b2b_first: got %h want %h", obs_pkt(), pack(200, 0, 0, 32, 5)); end
        tick();
        valid_in = 0;
        @(negedge clk);
        n_cmp++; if (obs_pkt() !== pack(204, 32, 32, 33, 6)) begin n_bad++; $display("FAIL b2b_second: got %h want %h", obs_pkt(), pack(204, 32, 32, 33, 6)); end
    endtask

    task automatic test_fl_exhaust();
        do_reset();
        for (int i = 0; i < 96; i++) begin
            set_instr(32'(i * 4), 1 + (i % 31), 0, 0, 1, 0);
            tick();
        end
        set_instr(32'd996, 0, 1, 2, 0, 0);
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL empty_nonwriter_ready: got %0b want 1", ready_in); end
        tick();
        set_instr(32'd1000, 9, 0, 0, 1, 0);
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL empty_writer_ready: got %0b want 0", ready_in); end
        n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL empty_free_count: got %0d want 0", free_count); end
        tick();
        commit_valid = 1;
        commit_pd_old = 7'd7;
        tick();
        commit_valid = 0;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL refill_ready: got %0b want 1", ready_in); end
        tick();
        valid_in = 0;
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b1 || data_out.pd_new !== 7'd7 || data_out.dec.pc !== 32'd1000) begin
            n_bad++; $display("FAIL refill_pd_new: got v=%0b pd=%0d pc=%0d want v=1 pd=7 pc=1000", valid_out, data_out.pd_new, data_out.dec.pc);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        set_instr(32'd300, 2, 0, 0, 1, 0);
        tick();
        set_instr(32'd304, 0, 1, 2, 0, 1);
        tick();
        set_instr(32'd308, 1, 0, 0, 1, 0);
        tick();
        valid_in = 0;
        mispredict = 1;
        @(negedge clk);
        n_cmp++; if (obs_pkt() !== pack(308, 0, 0, 33, 1)) begin n_bad++; $display("FAIL mp_addi: got %h want %h", obs_pkt(), pack(308, 0, 0, 33, 1)); end
        n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL mp_ready: got %0b want 0", ready_in); end
        tick();
        mispredict = 0;
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL mp_flush: got %0b want 0", valid_out); end
        n_cmp++; if (free_count !== 7'd95) begin n_bad++; $display("FAIL mp_free_count: got %0d want 95", free_count); end
        set_instr(32'd312, 3, 1, 2, 1, 0);
        tick();
        valid_in = 0;
        @(negedge clk);
        n_cmp++; if (obs_pkt() !== pack(312, 1, 32, 33, 3)) begin n_bad++; $display("FAIL mp_restored_map: got %h want %h", obs_pkt(), pack(312, 1, 32, 33, 3)); end
    endtask

    task automatic test_backpressure();
        int xfers;
        do_reset();
        ready_out = 0;
        set_instr(32'd400, 4, 1, 1, 1, 0);
        tick();
        set_instr(32'd404, 5, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (valid_out !== 1'b1 || obs_pkt() !== pack(400, 1, 1, 32, 4)) begin
                n_bad++; $display("FAIL bp_hold_%0d: got v=%0b %h want v=1 %h", k, valid_out, obs_pkt(), pack(400, 1, 1, 32, 4));
            end
            n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d: got %0b want 0", k, ready_in); end
            tick();
        end
        ready_out = 1;
        valid_in = 0;
        xfers = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (valid_out && ready_out) xfers++;
            tick();
        end
        n_cmp++; if (xfers != 1) begin n_bad++; $display("FAIL bp_transfers: got %0d want 1", xfers); end
    endtask

    task automatic test_branch_stall();
        do_reset();
        set_instr(32'd500, 0, 1, 2, 0, 1);
        tick();
        set_instr(32'd504, 0, 3, 4, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL br_stall_%0d: got %0b want 0", k, ready_in); end
            tick();
        end
        br_resolve_valid = 1;
        tick();
        br_resolve_valid = 0;
        @(negedge clk);
        n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL br_released: got %0b want 1", ready_in); end
        tick();
        set_instr(32'd508, 7, 0, 0, 1, 0);
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b1 || data_out.dec.pc !== 32'd504) begin
            n_bad++; $display("FAIL br_second_out: got v=%0b pc=%0d want v=1 pc=504", valid_out, data_out.dec.pc);
        end
        tick();
        set_instr(32'd512, 8, 0, 0, 1, 0);
        commit_valid = 1;
        commit_pd_old = 7'd32;
        tick();
        set_idle();
        @(negedge clk);
        n_cmp++; if (free_count !== 7'd95) begin n_bad++; $display("FAIL alloc_free_same_cycle: got %0d want 95", free_count); end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            data_in = '0;
            data_in.pc = 32'(cyc);
            data_in.opcode = 7'($urandom_range(0, 127));
            data_in.imm = $urandom;
            data_in.rs1 = 5'($urandom_range(0, 31));
            data_in.rs2 = 5'($urandom_range(0, 31));
            data_in.rd = 5'($urandom_range(0, 31));
            data_in.rd_we = 1'($urandom_range(0, 3) != 0);
            data_in.fu_br = 1'($urandom_range(0, 6) == 0);
            valid_in = ($urandom_range(0, 9) < 7);
            ready_out = ($urandom_range(0, 9) < 7);
            mispredict = ($urandom_range(0, 29) == 0);
            br_resolve_valid = ($urandom_range(0, 14) == 0);
            commit_valid = 0;
            commit_pd_old = '0;
            if (m_fl.size() + (m_ckv ? m_ck_allocs.size() : 0) < 96 && $urandom_range(0, 4) == 0) begin
                commit_valid = 1;
                commit_pd_old = 7'($urandom_range(0, 127));
            end
            @(negedge clk);
            n_cmp++; if (ready_in !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, ready_in, m_ready()); end
            n_cmp++; if (valid_out !== m_vout) begin n_bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", cyc, valid_out, m_vout); end
            n_cmp++; if (free_count !== 7'(m_fl.size())) begin n_bad++; $display("FAIL rnd_free_count c%0d: got %0d want %0d", cyc, free_count, m_fl.size()); end
            if (valid_out && ready_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra_xfer c%0d: got %h want none", cyc, obs_pkt());
                end else begin
                    e = exp_q.pop_front();
                    if (obs_pkt() !== e) begin n_bad++; $display("FAIL rnd_xfer c%0d: got %h want %h", cyc, obs_pkt(), e); end
                end
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        set_instr(32'd700, 3, 1, 2, 1, 0);
        tick();
        set_idle();
        @(negedge clk);
        reset = 0;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b want 0", valid_out); end
        n_cmp++; if (free_count !== 7'd96) begin n_bad++; $display("FAIL midrst_free_count: got %0d want 96", free_count); end
        n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %0b want 1", ready_in); end
        model_reset();
        @(posedge clk);
        #1 reset = 1;
    endtask

    initial begin
        reset = 0;
        set_idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_fl_exhaust();
        test_mispredict();
        test_backpressure();
        test_branch_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
